// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/UART frame sequencer: FSM states, flag bit positions, opcodes.
package alu_pkg;

    // 3-bit state encodings
    localparam logic [2:0] ST_WAIT_A   = 3'd0;
    localparam logic [2:0] ST_WAIT_B   = 3'd1;
    localparam logic [2:0] ST_WAIT_OP  = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_SEND_RES = 3'd4;
    localparam logic [2:0] ST_WAIT_RES = 3'd5;
    localparam logic [2:0] ST_SEND_FLG = 3'd6;
    localparam logic [2:0] ST_WAIT_FLG = 3'd7;

    typedef enum logic [2:0] {
        WAIT_A   = ST_WAIT_A,
        WAIT_B   = ST_WAIT_B,
        WAIT_OP  = ST_WAIT_OP,
        EXEC     = ST_EXEC,
        SEND_RES = ST_SEND_RES,
        WAIT_RES = ST_WAIT_RES,
        SEND_FLG = ST_SEND_FLG,
        WAIT_FLG = ST_WAIT_FLG
    } state_t;

    // Flags byte layout
    localparam int unsigned FLAG_W    = 5;
    localparam int unsigned FLAG_ZERO = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_NEG  = 3;
    localparam int unsigned FLAG_EXC  = 4;

    // ALU opcodes (not decoded by the sequencer)
    localparam logic [7:0] OP_ADD = 8'd8;
    localparam logic [7:0] OP_SUB = 8'd10;
    localparam logic [7:0] OP_AND = 8'd12;
    localparam logic [7:0] OP_OR  = 8'd13;
    localparam logic [7:0] OP_XOR = 8'd14;
    localparam logic [7:0] OP_SRA = 8'd3;
    localparam logic [7:0] OP_SRL = 8'd2;

    // Map the ALU flag bus {exception, negative, overflow, carry, zero} onto the flags byte positions
    function automatic logic [FLAG_W-1:0] pack_flags(input logic [4:0] alu_flags);
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_ZERO]  = alu_flags[0];
        f[FLAG_CARRY] = alu_flags[1];
        f[FLAG_OVF]   = alu_flags[2];
        f[FLAG_NEG]   = alu_flags[3];
        f[FLAG_EXC]   = alu_flags[4];
        return f;
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_frame_timeout.sv
// Inter-byte idle counter: clears on request, counts while enabled, flags the last allowed cycle.
module frame_timeout
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Idle cycle counter; clear has priority over counting
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_expired_c = i_enable && (count == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frame sequencer: collects A, B, opcode from the UART, runs the ALU, returns result and flags bytes.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,      // must be >= 5 so the flags byte fits
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [4:0]            i_alu_flags,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_operandA,
    output logic [DATA_WIDTH-1:0] o_operandB,
    output logic [DATA_WIDTH-1:0] o_opcode,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_frame_error,
    output logic                  o_rx_dropped
);

    state_t                state;
    logic [DATA_WIDTH-1:0] result_q;
    logic [FLAG_W-1:0]     flags_q;
    logic                  tmo_enable;
    logic                  tmo_clear;
    logic                  tmo_expired;
    logic                  not_accepting;

    // Timeout only runs between bytes of a started frame
    assign tmo_enable    = (state == WAIT_B) || (state == WAIT_OP);
    assign tmo_clear     = !tmo_enable || i_rx_done;
    assign not_accepting = (state == EXEC)     || (state == SEND_RES) || (state == WAIT_RES) ||
                           (state == SEND_FLG) || (state == WAIT_FLG);

    frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (tmo_enable),
        .i_clear     (tmo_clear),
        .o_expired_c (tmo_expired)
    );

    // Frame FSM with registered outputs; pulses default low and are set on the transition edge
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= WAIT_A;
            o_operandA    <= '0;
            o_operandB    <= '0;
            o_opcode      <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_error <= 1'b0;
            o_rx_dropped  <= 1'b0;
            result_q      <= '0;
            flags_q       <= '0;
        end else begin
            o_tx_start    <= 1'b0;
            o_frame_error <= 1'b0;
            o_rx_dropped  <= i_rx_done && not_accepting;

            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_operandA <= i_rx_data;
                        state      <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_operandB <= i_rx_data;
                        state      <= WAIT_OP;
                    end else if (tmo_expired) begin
                        o_frame_error <= 1'b1;
                        state         <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_opcode <= i_rx_data;
                        o_busy   <= 1'b1;
                        state    <= EXEC;
                    end else if (tmo_expired) begin
                        o_frame_error <= 1'b1;
                        state         <= WAIT_A;
                    end
                end
                EXEC: begin
                    // ALU has had one full cycle on the registered operands
                    result_q   <= i_alu_result;
                    flags_q    <= pack_flags(i_alu_flags);
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= SEND_RES;
                end
                SEND_RES: begin
                    o_tx_data <= result_q;
                    state     <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (i_tx_done) begin
                        o_tx_data  <= DATA_WIDTH'(flags_q);
                        o_tx_start <= 1'b1;
                        state      <= SEND_FLG;
                    end
                end
                SEND_FLG: begin
                    state <= WAIT_FLG;
                end
                WAIT_FLG: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a behavioural 8-bit ALU attached to the operand outputs.
module tb_alu_uart_ctrl;
    import alu_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [DW-1:0] i_rx_data = '0;
    logic          i_rx_done = 1'b0;
    logic [DW-1:0] alu_result;
    logic [4:0]    alu_flags;
    logic          i_tx_done = 1'b0;
    logic [DW-1:0] o_operandA;
    logic [DW-1:0] o_operandB;
    logic [DW-1:0] o_opcode;
    logic [DW-1:0] o_tx_data;
    logic          o_tx_start;
    logic          o_busy;
    logic          o_frame_error;
    logic          o_rx_dropped;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_uart_ctrl #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .i_alu_result  (alu_result),
        .i_alu_flags   (alu_flags),
        .i_tx_done     (i_tx_done),
        .o_operandA    (o_operandA),
        .o_operandB    (o_operandB),
        .o_opcode      (o_opcode),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .o_busy        (o_busy),
        .o_frame_error (o_frame_error),
        .o_rx_dropped  (o_rx_dropped)
    );

    // Behavioural ALU: flags bus is {exception, negative, overflow, carry, zero}
    logic [8:0] sum9;
    logic       f_c, f_v, f_e;
    always_comb begin
        sum9       = '0;
        alu_result = '0;
        f_c        = 1'b0;
        f_v        = 1'b0;
        f_e        = 1'b0;
        case (o_opcode)
            OP_ADD: begin
                sum9       = {1'b0, o_operandA} + {1'b0, o_operandB};
                alu_result = sum9[7:0];
                f_c        = sum9[8];
                f_v        = (o_operandA[7] == o_operandB[7]) && (alu_result[7] != o_operandA[7]);
            end
            OP_SUB: begin
                sum9       = {1'b0, o_operandA} - {1'b0, o_operandB};
                alu_result = sum9[7:0];
                f_c        = sum9[8];
                f_v        = (o_operandA[7] != o_operandB[7]) && (alu_result[7] != o_operandA[7]);
            end
            OP_AND:  alu_result = o_operandA & o_operandB;
            OP_OR:   alu_result = o_operandA | o_operandB;
            OP_XOR:  alu_result = o_operandA ^ o_operandB;
            OP_SRL:  alu_result = o_operandA >> o_operandB[2:0];
            OP_SRA:  alu_result = $signed(o_operandA) >>> o_operandB[2:0];
            default: f_e = 1'b1;
        endcase
        alu_flags = {f_e, alu_result[7], f_v, f_c, (alu_result == '0)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    // Leaves the bench in the EXEC cycle (one cycle after the opcode strobe)
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        check8("opA", o_operandA, a);
        check8("opB", o_operandB, b);
        check8("opcode", o_opcode, op);
    endtask

    // Starts in EXEC; walks result and flags bytes back to WAIT_A
    task automatic finish_frame(input logic [7:0] res, input logic [7:0] flg, input bit inject);
        check1("exec_busy", o_busy, 1'b1);
        check1("exec_no_start", o_tx_start, 1'b0);
        tick();
        check1("res_start", o_tx_start, 1'b1);
        check8("res_data", o_tx_data, res);
        tick();
        check1("res_start_once", o_tx_start, 1'b0);
        if (inject) begin
            send_byte(8'h55);
            check1("drop_pulse", o_rx_dropped, 1'b1);
            tick();
            check1("drop_single", o_rx_dropped, 1'b0);
        end
        repeat (2) tick();
        check8("res_hold", o_tx_data, res);
        check1("res_wait_no_start", o_tx_start, 1'b0);
        pulse_tx_done();
        check1("flg_start", o_tx_start, 1'b1);
        check8("flg_data", o_tx_data, flg);
        tick();
        check1("flg_start_once", o_tx_start, 1'b0);
        check1("flg_busy", o_busy, 1'b1);
        tick();
        pulse_tx_done();
        check1("done_busy", o_busy, 1'b0);
        check1("done_no_start", o_tx_start, 1'b0);
        check8("done_hold", o_tx_data, flg);
    endtask

    task automatic check_reset_outputs(input string tag);
        check8({tag, "_opA"}, o_operandA, 8'h00);
        check8({tag, "_opB"}, o_operandB, 8'h00);
        check8({tag, "_opc"}, o_opcode, 8'h00);
        check8({tag, "_txd"}, o_tx_data, 8'h00);
        check1({tag, "_start"}, o_tx_start, 1'b0);
        check1({tag, "_busy"}, o_busy, 1'b0);
        check1({tag, "_ferr"}, o_frame_error, 1'b0);
        check1({tag, "_drop"}, o_rx_dropped, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check_reset_outputs("rst");
        i_reset = 1'b0;
        tick();

        // Basic ADD and flag patterns
        send_frame(8'h05, 8'h03, OP_ADD); finish_frame(8'h08, 8'h00, 1'b0);
        send_frame(8'h7F, 8'h01, OP_ADD); finish_frame(8'h80, 8'h0C, 1'b0);
        send_frame(8'h03, 8'h05, OP_SUB); finish_frame(8'hFE, 8'h0A, 1'b0);
        send_frame(8'h5A, 8'h5A, OP_XOR); finish_frame(8'h00, 8'h01, 1'b0);
        send_frame(8'h90, 8'h02, OP_SRA); finish_frame(8'hE4, 8'h08, 1'b0);
        send_frame(8'h90, 8'h02, OP_SRL); finish_frame(8'h24, 8'h00, 1'b0);
        send_frame(8'h01, 8'h02, 8'h0F); finish_frame(8'h00, 8'h11, 1'b0);

        // Timeout in WAIT_B: expiry on the 16th idle cycle, error pulse the cycle after
        send_byte(8'h11);
        repeat (15) tick();
        check1("tmo_early", o_frame_error, 1'b0);
        tick();
        check1("tmo_pulse", o_frame_error, 1'b1);
        check8("tmo_opA_kept", o_operandA, 8'h11);
        check1("tmo_busy", o_busy, 1'b0);
        tick();
        check1("tmo_single", o_frame_error, 1'b0);
        send_frame(8'h0C, 8'h0A, OP_AND); finish_frame(8'h08, 8'h00, 1'b0);

        // Byte arriving on the expiry cycle wins
        send_byte(8'h22);
        repeat (15) tick();
        send_byte(8'h33);
        check1("race_no_err", o_frame_error, 1'b0);
        send_frame_tail: begin
            send_byte(OP_ADD);
            check1("race_no_err2", o_frame_error, 1'b0);
            check8("race_opB", o_operandB, 8'h33);
        end
        finish_frame(8'h55, 8'h00, 1'b0);

        // Byte dropped during WAIT_RES, then a clean frame
        send_frame(8'h21, 8'h43, OP_OR); finish_frame(8'h63, 8'h00, 1'b1);
        check8("drop_opA_kept", o_operandA, 8'h21);
        send_frame(8'h10, 8'h20, OP_ADD); finish_frame(8'h30, 8'h00, 1'b0);

        // Reset while in WAIT_FLG
        send_frame(8'h05, 8'h03, OP_ADD);
        tick();
        tick();
        pulse_tx_done();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_outputs("midrst");
        pulse_tx_done();
        for (int i = 0; i < 4; i++) begin
            check1("midrst_no_start", o_tx_start, 1'b0);
            tick();
        end
        send_frame(8'h7F, 8'h01, OP_ADD); finish_frame(8'h80, 8'h0C, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
